machine_cycle_sequencer: RTL and testbench

//  Parametrised successor to the fixed-length machine-cycle counter that steps the multi-cycle MIPS core.

---
 rtl/mips_seq_pkg.sv | 25 ++
 rtl/machine_cycle_sequencer_sat_counter.sv | 33 +++
 rtl/machine_cycle_sequencer.sv | 118 +++++++++++
 tb/tb_machine_cycle_sequencer.sv | 167 ++++++++++++++++
 4 files changed

// File: rtl/mips_seq_pkg.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Package     : mips_seq_pkg                                             |
// | Description : Phase numbering and default instruction lengths shared   |
// |               by the machine-cycle sequencer and the control FSM.      |
// | Revision    : 1.0 - initial release                                    |
// +------------------------------------------------------------------------+
package mips_seq_pkg;

    // Phase numbers driven onto count_state of the datapath.
    localparam int PH_IDLE   = 0;
    localparam int PH_FETCH  = 1;
    localparam int PH_DECODE = 2;
    localparam int PH_EXEC   = 3;  // EXEC / ADDR
    localparam int PH_WB     = 4;  // WB / MEM
    localparam int PH_DUMMY  = 5;  // MEM-DUMMY

    // Default instruction lengths, in phases.
    localparam int LEN_RTYPE  = 5;
    localparam int LEN_SW     = 5;
    localparam int LEN_LW     = 5;
    localparam int LEN_BRANCH = 3;

endpackage : mips_seq_pkg
`default_nettype wire

// File: rtl/machine_cycle_sequencer_sat_counter.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module      : sat_counter                                              |
// | Description : Up-counter that sticks at all-ones instead of wrapping.  |
// |               Compiled only when SEQ_RETIRE_COUNT_EN is defined.       |
// | Ports       : clk, reset (sync, active-high), inc, count[WIDTH-1:0]    |
// | Revision    : 1.0 - initial release                                    |
// +------------------------------------------------------------------------+
`ifdef SEQ_RETIRE_COUNT_EN
module sat_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    logic [WIDTH-1:0] r_count;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_count <= '0;
        end else if (inc && (r_count != '1)) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign count = r_count;

endmodule : sat_counter
`endif
`default_nettype wire

// File: rtl/machine_cycle_sequencer.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module      : machine_cycle_sequencer                                  |
// | Description : Generates machine-cycle phase numbers 1..len_q for a     |
// |               multi-cycle MIPS core. Length is latched per instruction |
// |               on FETCH entry, stall holds the phase, flag marks the    |
// |               retiring (last, unstalled) phase.                        |
// | Ports       : clk, reset (sync, active-high), enable, stall,           |
// |               cycle_len -> phase, flag, busy, len_q, retired           |
// | Config      : SEQ_RETIRE_COUNT_EN - when defined, retired counts       |
// |               retired instructions (saturating); otherwise tied to 0.  |
// | Revision    : 1.0 - initial release                                    |
// +------------------------------------------------------------------------+
module machine_cycle_sequencer
    import mips_seq_pkg::*;
#(
    parameter int CNT_WIDTH     = 3,
    parameter int MAX_PHASES    = 6,
    parameter int MIN_PHASES    = 2,
    parameter int RET_CNT_WIDTH = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     enable,
    input  logic                     stall,
    input  logic [CNT_WIDTH-1:0]     cycle_len,
    output logic [CNT_WIDTH-1:0]     phase,
    output logic                     flag,
    output logic                     busy,
    output logic [CNT_WIDTH-1:0]     len_q,
    output logic [RET_CNT_WIDTH-1:0] retired
);

    localparam logic [CNT_WIDTH-1:0] C_MIN   = CNT_WIDTH'(MIN_PHASES);
    localparam logic [CNT_WIDTH-1:0] C_MAX   = CNT_WIDTH'(MAX_PHASES);
    localparam logic [CNT_WIDTH-1:0] C_IDLE  = CNT_WIDTH'(PH_IDLE);
    localparam logic [CNT_WIDTH-1:0] C_FETCH = CNT_WIDTH'(PH_FETCH);

    logic [CNT_WIDTH-1:0] r_phase;
    logic [CNT_WIDTH-1:0] r_len_q;
    logic [CNT_WIDTH-1:0] w_phase_nxt;
    logic [CNT_WIDTH-1:0] w_len_nxt;
    logic [CNT_WIDTH-1:0] w_len_clamped;
    logic                 w_busy;
    logic                 w_flag;

    // Requested length forced into [MIN_PHASES, MAX_PHASES].
    always_comb begin
        w_len_clamped = cycle_len;
        if (cycle_len < C_MIN) begin
            w_len_clamped = C_MIN;
        end else if (cycle_len > C_MAX) begin
            w_len_clamped = C_MAX;
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_phase <= C_IDLE;
            r_len_q <= '0;
        end else begin
            r_phase <= w_phase_nxt;
            r_len_q <= w_len_nxt;
        end
    end

    // Next-state logic. A new instruction is started either from IDLE or
    // directly off the retiring phase, so back-to-back instructions carry
    // no idle bubble.
    always_comb begin
        w_phase_nxt = r_phase;
        w_len_nxt   = r_len_q;
        if (r_phase == C_IDLE) begin
            if (enable && !stall) begin
                w_phase_nxt = C_FETCH;
                w_len_nxt   = w_len_clamped;
            end
        end else if (!stall) begin
            if (r_phase == r_len_q) begin
                if (enable) begin
                    w_phase_nxt = C_FETCH;
                    w_len_nxt   = w_len_clamped;
                end else begin
                    w_phase_nxt = C_IDLE;
                end
            end else begin
                w_phase_nxt = r_phase + 1'b1;
            end
        end
    end

    // Output logic.
    always_comb begin
        w_busy = (r_phase != C_IDLE);
        w_flag = w_busy && (r_phase == r_len_q) && !stall;
    end

    assign phase = r_phase;
    assign len_q = r_len_q;
    assign busy  = w_busy;
    assign flag  = w_flag;

`ifdef SEQ_RETIRE_COUNT_EN
    sat_counter #(
        .WIDTH (RET_CNT_WIDTH)
    ) u_retired (
        .clk   (clk),
        .reset (reset),
        .inc   (w_flag),
        .count (retired)
    );
`else
    assign retired = '0;
`endif

endmodule : machine_cycle_sequencer
`default_nettype wire

// File: tb/tb_machine_cycle_sequencer.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module      : tb_machine_cycle_sequencer                               |
// | Description : Directed self-checking bench for machine_cycle_sequencer.|
// |               Expected retired count follows SEQ_RETIRE_COUNT_EN.      |
// | Revision    : 1.0 - initial release                                    |
// +------------------------------------------------------------------------+
module tb_machine_cycle_sequencer;

    logic        clk;
    logic        reset;
    logic        enable;
    logic        stall;
    logic [2:0]  cycle_len;
    logic [2:0]  phase;
    logic        flag;
    logic        busy;
    logic [2:0]  len_q;
    logic [15:0] retired;

    int n_cmp  = 0;
    int n_fail = 0;

    machine_cycle_sequencer dut (
        .clk       (clk),
        .reset     (reset),
        .enable    (enable),
        .stall     (stall),
        .cycle_len (cycle_len),
        .phase     (phase),
        .flag      (flag),
        .busy      (busy),
        .len_q     (len_q),
        .retired   (retired)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0] rexp(input int n);
`ifdef SEQ_RETIRE_COUNT_EN
        return 16'(n);
`else
        return 16'(n) & 16'd0;
`endif
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag, input int ph, input int fl, input int bz,
                           input int ln, input int rt, input bit check_len);
        chk({tag, ".phase"},   32'(phase),   32'(ph));
        chk({tag, ".flag"},    32'(flag),    32'(fl));
        chk({tag, ".busy"},    32'(busy),    32'(bz));
        chk({tag, ".retired"}, 32'(retired), 32'(rexp(rt)));
        if (check_len) chk({tag, ".len_q"}, 32'(len_q), 32'(ln));
    endtask

    // Assumes the DUT is at phase 1 of an instruction of length len.
    // Changes cycle_len mid-instruction (must be ignored until next FETCH).
    task automatic run_instr(input string tag, input int len, input int next_len, input int ret_before);
        for (int p = 1; p <= len; p++) begin
            chk_all(tag, p, (p == len) ? 1 : 0, 1, len, ret_before, 1'b1);
            if (p == 1) cycle_len = 3'(next_len);
            step();
        end
    endtask

    initial begin
        reset     = 1'b1;
        enable    = 1'b1;
        stall     = 1'b0;
        cycle_len = 3'd5;

        // 1: reset held three cycles with enable high
        for (int i = 0; i < 3; i++) begin
            step();
            chk_all("reset", 0, 0, 0, 0, 0, 1'b1);
        end

        // 2: three 5-phase instructions back to back
        reset = 1'b0;
        step();
        run_instr("len5a", 5, 5, 0);
        run_instr("len5b", 5, 5, 1);
        run_instr("len5c", 5, 3, 2);

        // 3: lengths 3 and 6 back to back, then clamps 0->2 and 7->6
        run_instr("len3",  3, 6, 3);
        run_instr("len6",  6, 0, 4);
        run_instr("clamp0", 2, 7, 5);
        run_instr("clamp7", 6, 5, 6);

        // 4: stall at phase 4 for four cycles, then at phase 5
        chk_all("st.p1", 1, 0, 1, 5, 7, 1'b1);
        step(); step(); step();
        chk_all("st.p4", 4, 0, 1, 5, 7, 1'b1);
        stall = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            chk_all("st.hold4", 4, 0, 1, 5, 7, 1'b1);
        end
        stall = 1'b0;
        step();
        chk_all("st.p5", 5, 1, 1, 5, 7, 1'b1);
        stall = 1'b1;
        #1;
        chk_all("st.p5stall", 5, 0, 1, 5, 7, 1'b1);
        step();
        chk_all("st.p5hold", 5, 0, 1, 5, 7, 1'b1);
        stall = 1'b0;
        #1;
        chk_all("st.p5go", 5, 1, 1, 5, 7, 1'b1);
        step();
        chk_all("st.next", 1, 0, 1, 5, 8, 1'b1);

        // 5: enable dropped at phase 2 -> run to completion, then IDLE
        step();
        chk_all("dis.p2", 2, 0, 1, 5, 8, 1'b1);
        enable = 1'b0;
        step();
        chk_all("dis.p3", 3, 0, 1, 5, 8, 1'b1);
        step();
        chk_all("dis.p4", 4, 0, 1, 5, 8, 1'b1);
        step();
        chk_all("dis.p5", 5, 1, 1, 5, 8, 1'b1);
        step();
        chk_all("dis.idle", 0, 0, 0, 0, 9, 1'b0);
        step();
        chk_all("dis.idle2", 0, 0, 0, 0, 9, 1'b0);

        // IDLE with stall high does not start; start one edge after release
        enable = 1'b1;
        stall  = 1'b1;
        step();
        chk_all("idle.stall", 0, 0, 0, 0, 9, 1'b0);
        stall = 1'b0;
        step();
        chk_all("idle.start", 1, 0, 1, 5, 9, 1'b1);

        // 6: reset at phase 3 aborts without retiring
        step(); step();
        chk_all("rst.p3", 3, 0, 1, 5, 9, 1'b1);
        reset = 1'b1;
        step();
        chk_all("rst.abort", 0, 0, 0, 0, 0, 1'b1);
        reset = 1'b0;
        step();
        chk_all("rst.restart", 1, 0, 1, 5, 0, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule : tb_machine_cycle_sequencer
`default_nettype wire
